// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC stage feeding the instruction ROM: next-PC select, stall/halt, address trap, fetch counter
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0040_0024,
    parameter int          ROM_DEPTH = 64,
    parameter int          COUNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [31:0]        branch_offset,
    input  logic               jump,
    input  logic [25:0]        jump_target,
    input  logic               jr,
    input  logic [31:0]        jr_target,
    input  logic               halt_req,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    output logic               fetch_valid,
    output logic               halted,
    output logic               addr_err,
    output logic [COUNT_W-1:0] fetch_count
);

    typedef enum logic [1:0] {START, RUN, HALT, ERR} state_t;

    // One bit wider so a window touching the top of the address space cannot overflow.
    localparam logic [32:0]        ROM_END   = {1'b0, RESET_PC} + 33'(4 * ROM_DEPTH);
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;
    localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

    state_t      state;
    logic [31:0] next_pc;
    logic        next_ok;

    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        next_pc = pc_plus4;
        if (jr)
            next_pc = jr_target;
        else if (jump)
            next_pc = {pc_plus4[31:28], jump_target, 2'b00};
        else if (branch_taken)
            next_pc = pc_plus4 + (branch_offset << 2);
        next_ok = (next_pc[1:0] == 2'b00) && (next_pc >= RESET_PC)
                  && ({1'b0, next_pc} < ROM_END);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= START;
            pc          <= RESET_PC;
            fetch_count <= '0;
            fetch_valid <= 1'b0;
            halted      <= 1'b0;
            addr_err    <= 1'b0;
        end else begin
            case (state)
                START: begin
                    state       <= RUN;
                    fetch_valid <= 1'b1;
                end
                RUN: begin
                    if (halt_req) begin
                        state       <= HALT;
                        fetch_valid <= 1'b0;
                        halted      <= 1'b1;
                    end else if (!stall) begin
                        if (next_ok) begin
                            pc <= next_pc;
                            if (fetch_count != COUNT_MAX)
                                fetch_count <= fetch_count + COUNT_ONE;
                        end else begin
                            state       <= ERR;
                            fetch_valid <= 1'b0;
                            addr_err    <= 1'b1;
                        end
                    end
                end
                default: state <= state;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed vector bench for pc_fetch_unit
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0, branch_taken = 1'b0, jump = 1'b0, jr = 1'b0, halt_req = 1'b0;
    logic [31:0] branch_offset = '0, jr_target = '0;
    logic [25:0] jump_target = '0;
    logic [31:0] pc, pc_plus4, pc_s, pc_plus4_s;
    logic        fetch_valid, halted, addr_err, fetch_valid_s, halted_s, addr_err_s;
    logic [31:0] fetch_count;
    logic [2:0]  fetch_count_s;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
        .branch_offset(branch_offset), .jump(jump), .jump_target(jump_target),
        .jr(jr), .jr_target(jr_target), .halt_req(halt_req),
        .pc(pc), .pc_plus4(pc_plus4), .fetch_valid(fetch_valid), .halted(halted),
        .addr_err(addr_err), .fetch_count(fetch_count)
    );

    // Narrow counter copy so saturation is reachable in a short run.
    pc_fetch_unit #(.COUNT_W(3)) dut_s (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
        .branch_offset(branch_offset), .jump(jump), .jump_target(jump_target),
        .jr(jr), .jr_target(jr_target), .halt_req(halt_req),
        .pc(pc_s), .pc_plus4(pc_plus4_s), .fetch_valid(fetch_valid_s), .halted(halted_s),
        .addr_err(addr_err_s), .fetch_count(fetch_count_s)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [31:0] boff;
        logic        jump;
        logic [25:0] jt;
        logic        jr;
        logic [31:0] jrt;
        logic        halt;
        logic [31:0] pc;
        int          cnt;
        logic        valid;
        logic        halted;
        logic        err;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, input logic st, input logic br, input logic [31:0] boff,
                       input logic jp, input logic [25:0] jt, input logic j, input logic [31:0] jrt,
                       input logic hl, input logic [31:0] epc, input int ecnt,
                       input logic ev, input logic eh, input logic ee);
        vec_t v;
        v.rst = rst; v.stall = st; v.br = br; v.boff = boff; v.jump = jp; v.jt = jt;
        v.jr = j; v.jrt = jrt; v.halt = hl; v.pc = epc; v.cnt = ecnt;
        v.valid = ev; v.halted = eh; v.err = ee;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset(input int idx);
        check($sformatf("rst%0d pc", idx), pc, 32'h0040_0024);
        check($sformatf("rst%0d count", idx), fetch_count, 32'd0);
        check($sformatf("rst%0d valid", idx), {31'd0, fetch_valid}, 32'd0);
        check($sformatf("rst%0d halted", idx), {31'd0, halted}, 32'd0);
        check($sformatf("rst%0d addr_err", idx), {31'd0, addr_err}, 32'd0);
    endtask

    initial begin
        // A: sequential, branch, jump priority, stall, jr, then an error trap that must stick
        add(1, 0, 0, 0,   1, 26'h0100040, 0, 0, 0, 32'h0040_0024, 0, 1, 0, 0);
        add(0, 0, 0, 0,   0, 0, 0, 0, 0, 32'h0040_0028, 1, 1, 0, 0);
        add(0, 0, 0, 0,   0, 0, 0, 0, 0, 32'h0040_002C, 2, 1, 0, 0);
        add(0, 0, 0, 0,   0, 0, 0, 0, 0, 32'h0040_0030, 3, 1, 0, 0);
        add(0, 0, 1, -32'sd2, 0, 0, 0, 0, 0, 32'h0040_002C, 4, 1, 0, 0);
        add(0, 0, 0, 0,   0, 0, 0, 0, 0, 32'h0040_0030, 5, 1, 0, 0);
        add(0, 0, 1, -32'sd2, 1, 26'h0100040, 0, 0, 0, 32'h0040_0100, 6, 1, 0, 0);
        for (int i = 0; i < 4; i++)
            add(0, 1, 0, 0, 1, 26'h0100009, 0, 0, 0, 32'h0040_0100, 6, 1, 0, 0);
        add(0, 0, 0, 0,   1, 26'h0100009, 0, 0, 0, 32'h0040_0024, 7, 1, 0, 0);
        add(0, 1, 0, 0,   0, 0, 1, 32'h0040_0026, 0, 32'h0040_0024, 7, 1, 0, 0);
        add(0, 0, 0, 0,   0, 0, 1, 32'h0040_0040, 0, 32'h0040_0040, 8, 1, 0, 0);
        add(0, 0, 1, 32'd4, 1, 26'h0100009, 1, 32'h0040_0050, 0, 32'h0040_0050, 9, 1, 0, 0);
        add(0, 0, 1, 32'd4, 0, 0, 0, 0, 0, 32'h0040_0064, 10, 1, 0, 0);
        add(0, 0, 0, 0,   0, 0, 1, 32'h0040_0026, 0, 32'h0040_0064, 10, 0, 0, 1);
        add(0, 0, 0, 0,   1, 26'h0100009, 0, 0, 0, 32'h0040_0064, 10, 0, 0, 1);
        add(0, 0, 0, 0,   0, 0, 0, 0, 1, 32'h0040_0064, 10, 0, 0, 1);
        // B: halt beats an invalid redirect; HALT is terminal
        add(1, 0, 0, 0,   0, 0, 0, 0, 0, 32'h0040_0024, 0, 1, 0, 0);
        add(0, 0, 0, 0,   0, 0, 1, 32'h0000_0003, 1, 32'h0040_0024, 0, 0, 1, 0);
        add(0, 0, 0, 0,   0, 0, 1, 32'h0040_0040, 0, 32'h0040_0024, 0, 0, 1, 0);
        // C/D: just above and just below the window
        add(1, 0, 0, 0,   0, 0, 0, 0, 0, 32'h0040_0024, 0, 1, 0, 0);
        add(0, 0, 0, 0,   0, 0, 1, 32'h0040_0124, 0, 32'h0040_0024, 0, 0, 0, 1);
        add(1, 0, 0, 0,   0, 0, 0, 0, 0, 32'h0040_0024, 0, 1, 0, 0);
        add(0, 0, 0, 0,   0, 0, 1, 32'h0040_0020, 0, 32'h0040_0024, 0, 0, 0, 1);
        // E: walk to the last ROM word, then fall off the end
        add(1, 0, 0, 0,   0, 0, 0, 0, 0, 32'h0040_0024, 0, 1, 0, 0);
        for (int i = 1; i <= 63; i++)
            add(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0024 + 4 * i, i, 1, 0, 0);
        add(0, 0, 0, 0,   0, 0, 0, 0, 0, 32'h0040_0120, 63, 0, 0, 1);
        add(1, 0, 0, 0,   0, 0, 0, 0, 0, 32'h0040_0024, 0, 1, 0, 0);

        @(posedge clk);
        #1;
        for (int i = 0; i < vq.size(); i++) begin
            if (vq[i].rst) begin
                stall = 0; branch_taken = 0; branch_offset = 0; jump = 0;
                jump_target = 0; jr = 0; jr_target = 0; halt_req = 0;
                #1 rst_n = 1'b0;
                #1 check_reset(i);
                #1 rst_n = 1'b1;
            end
            stall = vq[i].stall; branch_taken = vq[i].br; branch_offset = vq[i].boff;
            jump = vq[i].jump; jump_target = vq[i].jt; jr = vq[i].jr;
            jr_target = vq[i].jrt; halt_req = vq[i].halt;
            @(posedge clk);
            #1;
            check($sformatf("row%0d pc", i), pc, vq[i].pc);
            check($sformatf("row%0d pc_plus4", i), pc_plus4, vq[i].pc + 32'd4);
            check($sformatf("row%0d count", i), fetch_count, vq[i].cnt);
            check($sformatf("row%0d valid", i), {31'd0, fetch_valid}, {31'd0, vq[i].valid});
            check($sformatf("row%0d halted", i), {31'd0, halted}, {31'd0, vq[i].halted});
            check($sformatf("row%0d addr_err", i), {31'd0, addr_err}, {31'd0, vq[i].err});
            check($sformatf("row%0d sat_count", i), {29'd0, fetch_count_s},
                  (vq[i].cnt > 7) ? 32'd7 : vq[i].cnt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
